// File: rtl/ka_fork_ctrl_n_if.sv
// Request/ack bundle for the ka fork controller: one upstream target port
// fanned out to N_CH downstream initiator channels.
interface ka_fork_ctrl_n_if #(
  parameter int N_CH = 3
);
  logic            t_req;
  logic            t_ack;
  logic [N_CH-1:0] sel;
  logic [N_CH-1:0] i_req;
  logic [N_CH-1:0] i_ack;

  modport master (
    output t_req, sel, i_ack,
    input  t_ack, i_req
  );

  modport slave (
    input  t_req, sel, i_ack,
    output t_ack, i_req
  );
endinterface

// File: rtl/ka_fork_ctrl_n.sv
// N-way fork controller for the ka request/ack fabric with completion counter.
// Optional stall watchdog built when KA_FORK_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no transaction in flight; sel drives the fork directly
// ACTIVE | transaction open; mask_q/done_q track outstanding channels
module ka_fork_ctrl_n #(
  parameter int N_CH    = 3,
  parameter int CNT_W   = 16,
  parameter int TO_W    = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ka_fork_ctrl_n_if.slave       bus,
  output logic [CNT_W-1:0]      txn_cnt,
  output logic                  busy,
  input  logic                  clr_err,
  output logic                  err_to,
  output logic [N_CH-1:0]       err_ch
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [N_CH-1:0] mask_q, mask_nxt;
  logic [N_CH-1:0] done_q, done_nxt;
  logic [N_CH-1:0] m;
  logic [N_CH-1:0] i_req_c;
  logic            t_ack_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mask_q <= '0;
      done_q <= '0;
    end else begin
      state  <= state_nxt;
      mask_q <= mask_nxt;
      done_q <= done_nxt;
    end
  end

  // Outputs are gated by reset_n so nothing leaks out while reset is held.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    done_nxt  = done_q;
    m         = (state == IDLE) ? bus.sel : mask_q;
    i_req_c   = {N_CH{bus.t_req & reset_n}} & m & ~done_q;
    t_ack_c   = bus.t_req & reset_n & (&(~m | done_q | bus.i_ack));
    case (state)
      IDLE: begin
        if (bus.t_req && !t_ack_c) begin
          state_nxt = ACTIVE;
          mask_nxt  = bus.sel;
          done_nxt  = i_req_c & bus.i_ack;
        end
      end
      ACTIVE: begin
        if (t_ack_c) begin
          state_nxt = IDLE;
          mask_nxt  = '0;
          done_nxt  = '0;
        end else begin
          done_nxt  = done_q | (i_req_c & bus.i_ack);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.i_req = i_req_c;
  assign bus.t_ack = t_ack_c;
  assign busy      = (state == ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_cnt <= '0;
    end else if (bus.t_req && t_ack_c) begin
      txn_cnt <= txn_cnt + 1'b1;
    end
  end

`ifdef KA_FORK_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  logic [TO_W-1:0] wd_q;
  logic            wd_fire;

  // Fires only on the step that lands on the limit, so err_ch is captured once.
  assign wd_fire = (state == ACTIVE) && !t_ack_c && (wd_q == TO_LIM - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if ((state == ACTIVE) && !t_ack_c) begin
      if (wd_q != TO_LIM) wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_to <= 1'b0;
      err_ch <= '0;
    end else if (wd_fire) begin
      err_to <= 1'b1;
      err_ch <= mask_q & ~done_q;
    end else if (clr_err) begin
      err_to <= 1'b0;
      err_ch <= '0;
    end
  end
`else
  logic            unused_clr;
  logic [TO_W-1:0] unused_to;

  assign unused_clr = clr_err;
  assign unused_to  = TO_W'(TIMEOUT);
  assign err_to     = 1'b0;
  assign err_ch     = '0;
`endif

endmodule

// File: tb/tb_ka_fork_ctrl_n.sv
// Directed bench for ka_fork_ctrl_n (N_CH=3, CNT_W=4, TIMEOUT=8).
module tb_ka_fork_ctrl_n;
  localparam int N_CH    = 3;
  localparam int CNT_W   = 4;
  localparam int TO_W    = 12;
  localparam int TIMEOUT = 8;
`ifdef KA_FORK_TIMEOUT_EN
  localparam logic            EXP_TO = 1'b1;
  localparam logic [N_CH-1:0] EXP_CH = 3'b100;
`else
  localparam logic            EXP_TO = 1'b0;
  localparam logic [N_CH-1:0] EXP_CH = 3'b000;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clr_err = 1'b0;
  logic [CNT_W-1:0] txn_cnt;
  logic             busy;
  logic             err_to;
  logic [N_CH-1:0]  err_ch;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  ka_fork_ctrl_n_if #(.N_CH(N_CH)) bus ();

  ka_fork_ctrl_n #(.N_CH(N_CH), .CNT_W(CNT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .txn_cnt (txn_cnt),
    .busy    (busy),
    .clr_err (clr_err),
    .err_to  (err_to),
    .err_ch  (err_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.t_req = 1'b0;
    bus.sel   = '0;
    bus.i_ack = '0;
    repeat (2) @(posedge clk);
    check("rst_tack_held", 32'(bus.t_ack), 0);
    #1 reset_n = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(txn_cnt), 0);
    check("rst_ireq", 32'(bus.i_req), 0);
    check("rst_err_to", 32'(err_to), 0);

    // single-cycle fork
    bus.sel = 3'b101; bus.t_req = 1'b1; bus.i_ack = 3'b101;
    #1;
    check("sc_ireq", 32'(bus.i_req), 32'b101);
    check("sc_tack", 32'(bus.t_ack), 1);
    tick;
    check("sc_busy", 32'(busy), 0);
    check("sc_cnt", 32'(txn_cnt), 1);
    bus.t_req = 1'b0; bus.i_ack = '0;

    // staggered acks
    bus.sel = 3'b111; bus.t_req = 1'b1;
    #1;
    check("st_c0_ireq", 32'(bus.i_req), 32'b111);
    check("st_c0_tack", 32'(bus.t_ack), 0);
    tick;
    bus.i_ack = 3'b001;
    #1;
    check("st_c1_busy", 32'(busy), 1);
    check("st_c1_ireq", 32'(bus.i_req), 32'b111);
    check("st_c1_tack", 32'(bus.t_ack), 0);
    tick;
    bus.i_ack = '0;
    #1;
    check("st_c2_ireq", 32'(bus.i_req), 32'b110);
    tick;
    bus.i_ack = 3'b100;
    #1;
    check("st_c3_tack", 32'(bus.t_ack), 0);
    tick;
    bus.i_ack = '0;
    #1;
    check("st_c4_ireq", 32'(bus.i_req), 32'b010);
    tick;
    bus.i_ack = 3'b010;
    #1;
    check("st_c5_tack", 32'(bus.t_ack), 1);
    check("st_c5_busy", 32'(busy), 1);
    tick;
    bus.t_req = 1'b0; bus.i_ack = '0;
    #1;
    check("st_c6_busy", 32'(busy), 0);
    check("st_c6_cnt", 32'(txn_cnt), 2);

    // mask latch, with a t_req dropout mid-transaction
    bus.sel = 3'b001; bus.t_req = 1'b1;
    tick;
    check("ml_busy", 32'(busy), 1);
    bus.t_req = 1'b0;
    #1;
    check("ml_drop_ireq", 32'(bus.i_req), 0);
    check("ml_drop_tack", 32'(bus.t_ack), 0);
    tick;
    check("ml_drop_busy", 32'(busy), 1);
    bus.t_req = 1'b1; bus.sel = 3'b110; bus.i_ack = 3'b110;
    #1;
    check("ml_ireq", 32'(bus.i_req), 32'b001);
    check("ml_unreq_ack", 32'(bus.t_ack), 0);
    bus.i_ack = 3'b001;
    #1;
    check("ml_tack", 32'(bus.t_ack), 1);
    tick;
    bus.t_req = 1'b0; bus.i_ack = '0; bus.sel = '0;
    #1;
    check("ml_busy_end", 32'(busy), 0);
    check("ml_cnt", 32'(txn_cnt), 3);

    // zero mask, counter wrap
    exp_cnt = 4'd3;
    bus.sel = '0; bus.t_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("zm_tack", 32'(bus.t_ack), 1);
      check("zm_ireq", 32'(bus.i_req), 0);
      tick;
      exp_cnt = exp_cnt + 4'd1;
      check("zm_cnt", 32'(txn_cnt), 32'(exp_cnt));
    end
    bus.t_req = 1'b0;
    check("zm_busy", 32'(busy), 0);

    // reset mid-transaction
    bus.sel = 3'b011; bus.t_req = 1'b1; bus.i_ack = 3'b001;
    tick;
    bus.i_ack = '0;
    #1;
    check("rm_ireq", 32'(bus.i_req), 32'b010);
    check("rm_busy", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    check("rm_tack0", 32'(bus.t_ack), 0);
    check("rm_ireq0", 32'(bus.i_req), 0);
    check("rm_busy0", 32'(busy), 0);
    check("rm_cnt0", 32'(txn_cnt), 0);
    #2 reset_n = 1'b1;
    #1;
    check("rm_rereq", 32'(bus.i_req), 32'b011);
    bus.i_ack = 3'b011;
    #1;
    check("rm_tack", 32'(bus.t_ack), 1);
    tick;
    bus.t_req = 1'b0; bus.i_ack = '0;
    check("rm_cnt", 32'(txn_cnt), 1);

    // watchdog
    bus.sel = 3'b110; bus.t_req = 1'b1; bus.i_ack = 3'b010;
    tick;
    bus.i_ack = '0;
    bus.sel   = '0;
    for (int k = 0; k < 7; k++) tick;
    check("to_pre_err", 32'(err_to), 0);
    check("to_pre_busy", 32'(busy), 1);
    tick;
    check("to_err", 32'(err_to), 32'(EXP_TO));
    check("to_err_ch", 32'(err_ch), 32'(EXP_CH));
    bus.i_ack = 3'b100;
    #1;
    check("to_late_tack", 32'(bus.t_ack), 1);
    tick;
    bus.t_req = 1'b0; bus.i_ack = '0;
    check("to_done_busy", 32'(busy), 0);
    check("to_cnt", 32'(txn_cnt), 2);
    tick;
    check("to_sticky", 32'(err_to), 32'(EXP_TO));
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    check("to_clr", 32'(err_to), 0);
    check("to_clr_ch", 32'(err_ch), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
